pipe_chain: RTL and testbench
=============================

# pipe_chain

Parametrised N-stage pipeline register chain with per-stage stall requests, global flush and bubble insertion, generalising the fixed IF/ID/EX/MEM/WB stage registers of the core. One instance replaces the hand-written inter-stage registers and their stall/flush control; payload width and stage count are parameters. Two saturating counters report stall and bubble cycles for performance bring-up.

## Interface
- WIDTH, 32, payload bits per stage (1..128)
- NSTAGE, 4, number of register stages (2..8); stage 0 is nearest the fetch side
- CNT_W, 16, width of the performance counters

- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream offers payload this cycle
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  upstream payload is accepted at this edge
- stall_req  in  NSTAGE  bit k: stage k must hold its contents
- flush_i  in  1  kill all in-flight payloads (exception/redirect)
- cnt_clr  in  1  synchronous clear of both counters
- stage_valid_o  out  NSTAGE  valid bit of each stage register
- stage_data_o  out  NSTAGE*WIDTH  stage k payload at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  = stage_valid_o[NSTAGE-1]
- out_data  out  WIDTH  = payload of stage NSTAGE-1
- stall_cnt_o  out  CNT_W  cycles in which in_ready was low because of a stall
- bubble_cnt_o  out  CNT_W  cycles in which at least one bubble was inserted

## Operation
- hold[k] = OR of stall_req[NSTAGE-1:k]; a stall at stage k freezes k and every upstream stage (hold is monotonic: hold[k] implies hold[k-1]).
- Per rising edge, priority order:
  - flush_i=1: every valid bit <= 0, every payload <= 0; stall_req ignored.
  - else stage k with hold[k]=1: valid and payload unchanged.
  - else stage k>=1 with hold[k-1]=1: bubble: valid <= 0, payload <= 0.
  - else stage k>=1: valid/payload <= stage k-1.
  - else stage 0: valid <= in_valid, payload <= in_data (payload loaded even when in_valid=0).
- in_ready = ~hold[0] & ~flush_i (combinational). in_valid=1 with in_ready=0 is not accepted; upstream holds it.
- stall_req on an invalid stage is honoured identically (no valid qualification).
- stall_cnt_o: +1 per edge where hold[0]=1 and flush_i=0.
- bubble_cnt_o: +1 per edge where flush_i=0 and some k>=1 has hold[k-1]=1, hold[k]=0 (at most one bubble point exists per cycle).
- Counters saturate at all-ones; cnt_clr=1 loads 0 and overrides the increment that cycle; flush does not clear counters.

## Timing
- Reset (rst_n=0, immediate): all valid bits 0, all payloads 0, both counters 0, so out_valid=0, out_data=0; in_ready follows its equation (1 if no stall_req and no flush).
- Latency: payload accepted at edge t appears at stage NSTAGE-1 after edge t+NSTAGE-1, i.e. out_valid high NSTAGE-1 cycles after the accept cycle with no stalls; throughput 1/cycle.
- Each cycle of stall_req[k] adds exactly one cycle of latency to payloads at stages <=k and inserts one bubble at stage k+1 (if k<NSTAGE-1).
- stall_req[NSTAGE-1] freezes the whole chain; no bubble; out_valid/out_data held.
- Flush effective at the same edge it is sampled; the payload offered that cycle is dropped (in_ready=0).
- Reset asserted mid-operation discards all contents; first accept possible at the first edge after rst_n rises.

## Test plan
- NSTAGE=4: stream 0x11,0x22,0x33,... with in_valid=1, no stalls -> out_data=0x11 with out_valid=1 three cycles after the accept edge, then one new value per cycle; counters stay 0.
- stall_req=4'b0010 for 2 cycles mid-stream -> stages 0-1 frozen, stage 2 shows two bubbles (valid=0, data=0), in_ready=0 two cycles, stall_cnt_o=2, bubble_cnt_o=2, no payload lost or duplicated at output.
- stall_req=4'b1000 for 3 cycles -> out_data/out_valid held 3 cycles, bubble_cnt_o unchanged, stall_cnt_o=3.
- Full pipe, flush_i=1 with stall_req=4'b0100 same cycle -> next edge all stage_valid_o=0, all data 0; offered payload not accepted; stall_cnt_o unchanged.
- Force stall_req[0]=1 for 2^CNT_W+5 cycles (CNT_W=4) -> stall_cnt_o sticks at 15; cnt_clr pulse -> 0 next edge.
- Assert rst_n=0 asynchronously between edges with full pipe -> outputs and counters 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_chain_if.sv
// Upstream handshake and downstream output of the pipeline register chain.
// The bench or upstream logic drives the master side; pipe_chain is the slave.
interface pipe_chain_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_chain.sv
// N-stage pipeline register chain with per-stage stall, global flush and bubble insertion.
// Saturating counters report stall cycles and bubble-insertion cycles.
module pipe_chain #(
  parameter int WIDTH  = 32,
  parameter int NSTAGE = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipe_chain_if.slave              bus,
  input  logic [NSTAGE-1:0]        stall_req,
  input  logic                     flush_i,
  input  logic                     cnt_clr,
  output logic [NSTAGE-1:0]        stage_valid_o,
  output logic [NSTAGE*WIDTH-1:0]  stage_data_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         bubble_cnt_o
);

  logic [NSTAGE-1:0]             w_hold;
  logic                          w_bubble_any;
  logic [NSTAGE-1:0]             r_valid;
  logic [NSTAGE-1:0][WIDTH-1:0]  r_data;
  logic [CNT_W-1:0]              r_stall_cnt;
  logic [CNT_W-1:0]              r_bubble_cnt;

  // hold[k]: any stall at stage k or downstream of it
  for (genvar k = 0; k < NSTAGE; k++) begin : g_hold
    assign w_hold[k] = |(stall_req >> k);
  end

  assign w_bubble_any = |(w_hold[NSTAGE-2:0] & ~w_hold[NSTAGE-1:1]);

  assign bus.in_ready  = ~w_hold[0] & ~flush_i;
  assign bus.out_valid = r_valid[NSTAGE-1];
  assign bus.out_data  = r_data[NSTAGE-1];
  assign stage_valid_o = r_valid;
  assign stage_data_o  = r_data;
  assign stall_cnt_o   = r_stall_cnt;
  assign bubble_cnt_o  = r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      if (!w_hold[0]) begin
        r_valid[0] <= bus.in_valid;
        r_data[0]  <= bus.in_data;
      end
      for (int k = 1; k < NSTAGE; k++) begin
        if (w_hold[k]) begin
          r_valid[k] <= r_valid[k];
          r_data[k]  <= r_data[k];
        end else if (w_hold[k-1]) begin
          r_valid[k] <= 1'b0;
          r_data[k]  <= '0;
        end else begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_data[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_hold[0] && !flush_i && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_bubble_any && !flush_i && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus random traffic
// compared every cycle against a stage-array reference model.
module tb_pipe_chain;
  localparam int WIDTH  = 16;
  localparam int NSTAGE = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NSTAGE-1:0]       stall_req = '0;
  logic                    flush_i = 1'b0;
  logic                    cnt_clr = 1'b0;
  logic [NSTAGE-1:0]       stage_valid_o;
  logic [NSTAGE*WIDTH-1:0] stage_data_o;
  logic [CNT_W-1:0]        stall_cnt_o;
  logic [CNT_W-1:0]        bubble_cnt_o;

  pipe_chain_if #(.WIDTH(WIDTH)) bus ();

  pipe_chain #(.WIDTH(WIDTH), .NSTAGE(NSTAGE), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .stall_req     (stall_req),
    .flush_i       (flush_i),
    .cnt_clr       (cnt_clr),
    .stage_valid_o (stage_valid_o),
    .stage_data_o  (stage_data_o),
    .stall_cnt_o   (stall_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // reference model: plain arrays, highest stalled stage decides the freeze point
  logic             m_v [NSTAGE];
  logic [WIDTH-1:0] m_d [NSTAGE];
  int               m_sc, m_bc;
  bit               last_acc;

  function automatic int top_stall();
    int s = -1;
    for (int k = 0; k < NSTAGE; k++) if (stall_req[k]) s = k;
    return s;
  endfunction

  function automatic logic exp_ready();
    return (top_stall() < 0) && !flush_i;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NSTAGE; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
    m_sc = 0; m_bc = 0;
  endtask

  task automatic m_step();
    int s = top_stall();
    last_acc = exp_ready() && bus.in_valid;
    if (flush_i) begin
      for (int k = 0; k < NSTAGE; k++) begin m_v[k] = 1'b0; m_d[k] = '0; end
    end else begin
      for (int k = NSTAGE-1; k >= 0; k--) begin
        if (k <= s) ;
        else if (k >= 1 && k == s+1) begin m_v[k] = 1'b0; m_d[k] = '0; end
        else if (k == 0) begin m_v[0] = bus.in_valid; m_d[0] = bus.in_data; end
        else begin m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; end
      end
    end
    if (cnt_clr) begin m_sc = 0; m_bc = 0; end
    else if (!flush_i) begin
      if (s >= 0 && m_sc < CMAX) m_sc++;
      if (s >= 0 && s < NSTAGE-1 && m_bc < CMAX) m_bc++;
    end
  endtask

  task automatic cmp_state();
    logic [NSTAGE-1:0]       ev;
    logic [NSTAGE*WIDTH-1:0] ed;
    for (int k = 0; k < NSTAGE; k++) begin
      ev[k] = m_v[k];
      ed[k*WIDTH +: WIDTH] = m_d[k];
    end
    chk("stage_valid", 64'(stage_valid_o), 64'(ev));
    chk("stage_data", 64'(stage_data_o), 64'(ed));
    chk("out_valid", 64'(bus.out_valid), 64'(m_v[NSTAGE-1]));
    chk("out_data", 64'(bus.out_data), 64'(m_d[NSTAGE-1]));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_sc));
    chk("bubble_cnt", 64'(bubble_cnt_o), 64'(m_bc));
  endtask

  // inputs change only right after the post-edge sample, well away from the edge
  task automatic tick();
    #1 chk("in_ready", 64'(bus.in_ready), 64'(exp_ready()));
    @(posedge clk);
    m_step();
    #1 cmp_state();
  endtask

  logic [WIDTH-1:0] nxt;

  task automatic drive(input logic v, input logic [NSTAGE-1:0] st, input logic fl, input logic clr);
    bus.in_valid = v; bus.in_data = nxt; stall_req = st; flush_i = fl; cnt_clr = clr;
  endtask

  task automatic stream(input int n, input logic [NSTAGE-1:0] st);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, st, 1'b0, 1'b0);
      tick();
      if (last_acc) nxt = nxt + 16'h11;
    end
  endtask

  int sc0, bc0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    nxt = 16'h11;
    m_reset();
    #2;
    cmp_state();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    #1 rst_n = 1'b1;

    // uninterrupted stream: first payload reaches the output after edge t+3
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, '0, 1'b0, 1'b0);
      tick();
      nxt = nxt + 16'h11;
      if (i == 3) begin
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_data", 64'(bus.out_data), 64'h11);
      end
    end
    chk("stream_cnt", 64'({stall_cnt_o, bubble_cnt_o}), 64'd0);

    sc0 = m_sc; bc0 = m_bc;
    stream(2, 4'b0010);
    chk("st1_stall", 64'(stall_cnt_o), 64'(sc0 + 2));
    chk("st1_bubble", 64'(bubble_cnt_o), 64'(bc0 + 2));
    stream(4, '0);

    sc0 = m_sc; bc0 = m_bc;
    stream(3, 4'b1000);
    chk("st3_stall", 64'(stall_cnt_o), 64'(sc0 + 3));
    chk("st3_bubble", 64'(bubble_cnt_o), 64'(bc0));
    stream(4, '0);

    sc0 = m_sc;
    drive(1'b1, 4'b0100, 1'b1, 1'b0);
    tick();
    chk("flush_valid", 64'(stage_valid_o), 64'd0);
    chk("flush_data", 64'(stage_data_o), 64'd0);
    chk("flush_stall", 64'(stall_cnt_o), 64'(sc0));
    stream(5, '0);

    // asynchronous reset between edges with a full pipe
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    cmp_state();
    #1 rst_n = 1'b1;

    stream(4, '0);
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    chk("sat_stall", 64'(stall_cnt_o), 64'(CMAX));
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("clr_stall", 64'(stall_cnt_o), 64'd0);
    chk("clr_bubble", 64'(bubble_cnt_o), 64'd0);

    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom_range(0, 3) != 0);
      bus.in_data  = WIDTH'($urandom);
      stall_req    = ($urandom_range(0, 3) == 0) ? NSTAGE'($urandom) : '0;
      flush_i      = ($urandom_range(0, 19) == 0);
      cnt_clr      = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
